// File: rtl/ahb3lite_sdram_arbiter.sv
// Round-robin arbiter that shares the SDRAM command sequencer between the AHB ports and the refresh timer.
// Refresh has priority over ports, and a bounded refresh wait overrides a port's lock.
module ahb3lite_sdram_arbiter #(
  parameter int unsigned AHB_PORTS    = 2,
  parameter int unsigned RFR_MAX_WAIT = 16
) (
  input  logic                                         HCLK,
  input  logic                                         HRESETn,
  input  logic [AHB_PORTS-1:0]                         req_i,
  input  logic [AHB_PORTS-1:0]                         lock_i,
  input  logic                                         done_i,
  input  logic                                         rfr_req_i,
  input  logic                                         rfr_done_i,
  output logic [AHB_PORTS-1:0]                         gnt_o,
  output logic [((AHB_PORTS > 1) ? $clog2(AHB_PORTS) : 1)-1:0] gnt_id_o,
  output logic                                         rfr_gnt_o,
  output logic                                         rfr_urgent_o
);

  localparam int unsigned IDW = (AHB_PORTS > 1) ? $clog2(AHB_PORTS) : 1;
  localparam int unsigned WW  = $clog2(RFR_MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PORT    = 2'd1,
    REFRESH = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDW-1:0]         owner_q, owner_d;
  logic [IDW-1:0]         last_q, last_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic [AHB_PORTS-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]         gnt_id_q, gnt_id_d;
  logic                   rfr_gnt_q, rfr_gnt_d;
  logic                   urgent;
  logic                   found;
  logic [IDW-1:0]         pick;
  int unsigned            cand;

  assign urgent = (wait_q == WW'(RFR_MAX_WAIT));

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    // Search starts just after the most recent owner, wrapping around.
    for (int unsigned i = 1; i <= AHB_PORTS; i++) begin
      cand = (32'(last_q) + i) % AHB_PORTS;
      if (!found && req_i[cand]) begin
        found = 1'b1;
        pick  = IDW'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (rfr_req_i) begin
          state_d = REFRESH;
        end else if (found) begin
          state_d = PORT;
          owner_d = pick;
          last_d  = pick;
        end
      end
      PORT: begin
        if (done_i && !(lock_i[owner_q] && req_i[owner_q] && !urgent)) begin
          state_d = IDLE;
        end
      end
      REFRESH: begin
        if (rfr_done_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d == REFRESH && state_q != REFRESH) begin
      wait_d = '0;
    end else if (rfr_req_i && state_q != REFRESH && !urgent) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Grants decode the current state, so entering PORT/REFRESH shows one cycle later.
  always_comb begin
    gnt_d     = '0;
    gnt_id_d  = '0;
    rfr_gnt_d = (state_q == REFRESH);
    if (state_q == PORT) begin
      gnt_d[owner_q] = 1'b1;
      gnt_id_d       = owner_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_q    <= IDW'(AHB_PORTS - 1);
      wait_q    <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      rfr_gnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      wait_q    <= wait_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      rfr_gnt_q <= rfr_gnt_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign gnt_id_o     = (AHB_PORTS == 1) ? '0 : gnt_id_q;
  assign rfr_gnt_o    = rfr_gnt_q;
  assign rfr_urgent_o = urgent;

endmodule

// File: tb/tb_ahb3lite_sdram_arbiter.sv
// Directed bench for ahb3lite_sdram_arbiter: two ports, refresh wait limit of 8.
module tb_ahb3lite_sdram_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [1:0] req_i;
  logic [1:0] lock_i;
  logic       done_i;
  logic       rfr_req_i;
  logic       rfr_done_i;
  logic [1:0] gnt_o;
  logic [0:0] gnt_id_o;
  logic       rfr_gnt_o;
  logic       rfr_urgent_o;

  int checks = 0;
  int errors = 0;

  ahb3lite_sdram_arbiter #(
    .AHB_PORTS    (2),
    .RFR_MAX_WAIT (8)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req_i        (req_i),
    .lock_i       (lock_i),
    .done_i       (done_i),
    .rfr_req_i    (rfr_req_i),
    .rfr_done_i   (rfr_done_i),
    .gnt_o        (gnt_o),
    .gnt_id_o     (gnt_id_o),
    .rfr_gnt_o    (rfr_gnt_o),
    .rfr_urgent_o (rfr_urgent_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] g, input logic gid,
                         input logic rg, input logic urg);
    chk({tag, ".gnt"},     32'(gnt_o),        32'(g));
    if (g != 2'b00) chk({tag, ".gnt_id"}, 32'(gnt_id_o), 32'(gid));
    chk({tag, ".rfr_gnt"}, 32'(rfr_gnt_o),    32'(rg));
    chk({tag, ".urgent"},  32'(rfr_urgent_o), 32'(urg));
  endtask

  initial begin
    logic [1:0] exp_g;
    logic       exp_id;
    HRESETn    = 1'b0;
    req_i      = 2'b11;
    lock_i     = 2'b00;
    done_i     = 1'b0;
    rfr_req_i  = 1'b1;
    rfr_done_i = 1'b0;

    // Reset with requests and refresh pending: everything stays quiet.
    #2;
    chk_out("rst_async", 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    chk_out("rst_held", 2'b00, 1'b0, 1'b0, 1'b0);

    rfr_req_i = 1'b0;
    HRESETn   = 1'b1;
    tick();
    chk_out("rel_edge1", 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("rel_edge2", 2'b01, 1'b0, 1'b0, 1'b0);

    // Fairness: done every 4th cycle, one empty cycle between owners.
    exp_g = 2'b01;
    for (int r = 0; r < 4; r++) begin
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      chk_out("fair_done", exp_g, exp_g[1], 1'b0, 1'b0);
      tick();
      chk_out("fair_bubble", 2'b00, 1'b0, 1'b0, 1'b0);
      exp_g  = ~exp_g;
      exp_id = exp_g[1];
      tick();
      chk_out("fair_new", exp_g, exp_id, 1'b0, 1'b0);
      tick();
      chk_out("fair_hold", exp_g, exp_id, 1'b0, 1'b0);
    end

    // Refresh priority: port 0 owns, port 1 waits, refresh raised.
    rfr_req_i = 1'b1;
    tick();
    chk_out("rp_hold", 2'b01, 1'b0, 1'b0, 1'b0);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    chk_out("rp_done", 2'b01, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("rp_idle", 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("rp_rgnt", 2'b00, 1'b0, 1'b1, 1'b0);
    rfr_req_i  = 1'b0;
    rfr_done_i = 1'b1;
    tick();
    rfr_done_i = 1'b0;
    chk_out("rp_rdone", 2'b00, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("rp_bubble", 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("rp_port1", 2'b10, 1'b1, 1'b0, 1'b0);

    // Spurious rfr_done in PORT, then spurious done in IDLE.
    rfr_done_i = 1'b1;
    tick();
    rfr_done_i = 1'b0;
    chk_out("sp_rdone", 2'b10, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("sp_rdone2", 2'b10, 1'b1, 1'b0, 1'b0);
    req_i  = 2'b00;
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    tick();
    chk_out("sp_idle", 2'b00, 1'b0, 1'b0, 1'b0);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    tick();
    chk_out("sp_done_idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Lock and urgency: port 1 locked, done every 3 cycles, refresh rises.
    req_i  = 2'b10;
    lock_i = 2'b10;
    tick();
    chk_out("lk_bubble", 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("lk_gnt", 2'b10, 1'b1, 1'b0, 1'b0);
    rfr_req_i = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      done_i = (c == 2 || c == 5 || c == 8 || c == 11);
      tick();
      done_i = 1'b0;
      chk_out($sformatf("lk_c%0d", c),
              (c <= 11) ? 2'b10 : 2'b00, 1'b1,
              (c >= 13), (c >= 8 && c <= 11));
    end

    // Reset while refresh is granted: grants fall without a clock edge.
    rfr_req_i = 1'b0;
    req_i     = 2'b00;
    lock_i    = 2'b00;
    #2;
    HRESETn = 1'b0;
    #1;
    chk_out("rst_mid_rfr", 2'b00, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
